// File: rtl/iccm_arbiter_if.sv
// ---------------------------------------------------------------------------
// iccm_arbiter_if
//
// Bundles every bus signal around the ICCM arbiter: the two host request /
// response channels and the single-port memory channel.
//
//   h0_*   core instruction-fetch port (read-only)
//   h1_*   loader/debug port (read and write, byte mask in h1_we)
//   mem_*  towards instr_mem_top (one-cycle read latency)
//
// Modports:
//   slave  - the arbiter's view: it serves the hosts and drives the memory.
//   master - the environment's view: hosts plus the memory itself.
// ---------------------------------------------------------------------------
interface iccm_arbiter_if;

    // Host 0: instruction fetch
    logic        h0_req;
    logic [31:0] h0_addr;
    logic        h0_gnt;
    logic        h0_rvalid;
    logic [31:0] h0_rdata;
    logic        h0_err;

    // Host 1: loader / debug
    logic        h1_req;
    logic [31:0] h1_addr;
    logic [3:0]  h1_we;
    logic [31:0] h1_wdata;
    logic        h1_gnt;
    logic        h1_rvalid;
    logic [31:0] h1_rdata;
    logic        h1_err;

    // Memory side
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    modport slave (
        input  h0_req, h0_addr,
        output h0_gnt, h0_rvalid, h0_rdata, h0_err,
        input  h1_req, h1_addr, h1_we, h1_wdata,
        output h1_gnt, h1_rvalid, h1_rdata, h1_err,
        output mem_req, mem_addr, mem_wdata, mem_we,
        input  mem_rdata, mem_rvalid
    );

    modport master (
        output h0_req, h0_addr,
        input  h0_gnt, h0_rvalid, h0_rdata, h0_err,
        output h1_req, h1_addr, h1_we, h1_wdata,
        input  h1_gnt, h1_rvalid, h1_rdata, h1_err,
        input  mem_req, mem_addr, mem_wdata, mem_we,
        output mem_rdata, mem_rvalid
    );

endinterface

// File: rtl/iccm_arbiter.sv
// ---------------------------------------------------------------------------
// iccm_arbiter
//
// Two-host round-robin arbiter and address decoder in front of the
// single-port ICCM (instr_mem_top). Host 0 fetches (read-only), host 1 loads
// (read/write). Grants are combinational in the request cycle; the response
// comes back exactly one cycle later, steered by a registered owner tag.
// Accesses outside the ICCM window are granted but never reach memory and
// come back with err set.
//
// Ports:
//   clock  - single clock
//   reset  - synchronous, active-low
//   bus    - iccm_arbiter_if.slave (host channels h0/h1 and memory channel)
//
// Parameters:
//   BASE_ADDR   - byte base of the ICCM window (word aligned)
//   DEPTH_WORDS - number of 32-bit words, at most 4096
// ---------------------------------------------------------------------------
module iccm_arbiter #(
    parameter logic [31:0] BASE_ADDR   = 32'h0010_0000,
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic          clock,
    input  logic          reset,
    iccm_arbiter_if.slave bus
);

    // Window bounds are compared in 33 bits so a window ending at 4 GiB
    // cannot wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    // The window is at most 16 KiB and BASE_ADDR is word aligned, so the
    // word offset only depends on byte-address bits [13:2].
    localparam logic [11:0] BASE_WORD = BASE_ADDR[13:2];

    typedef struct packed {
        logic valid;
        logic host;
        logic is_write;
        logic err;
    } tag_t;

    function automatic logic in_window(input logic [31:0] addr);
        logic [32:0] a;
        a = {1'b0, addr};
        return (a >= WIN_LO) && (a < WIN_HI);
    endfunction

    logic  last_q, last_d;
    tag_t  tag_q, tag_d;
    logic  fault_q, fault_d;

    logic        h1_write;
    logic        hit0, hit1;
    logic        gnt0, gnt1;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_we;

    logic        rsp_read_hit;
    logic        rsp_err;
    logic [31:0] rsp_data;

    assign h1_write = |bus.h1_we;

    // Alignment is enforced for fetches and for loader writes; a loader
    // read with a misaligned address simply returns the containing word.
    assign hit0 = in_window(bus.h0_addr) && (bus.h0_addr[1:0] == 2'b00);
    assign hit1 = in_window(bus.h1_addr) && (!h1_write || (bus.h1_addr[1:0] == 2'b00));

    // Arbitration, memory request decode and next tag.
    // last_q records the host granted most recently; on a tie the other
    // host wins, which gives strict alternation under full contention.
    always_comb begin
        gnt0      = bus.h0_req && (!bus.h1_req || last_q);
        gnt1      = bus.h1_req && (!bus.h0_req || !last_q);

        last_d    = last_q;
        tag_d     = '0;
        mem_req   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;

        if (gnt0) begin
            last_d         = 1'b0;
            tag_d.valid    = 1'b1;
            tag_d.host     = 1'b0;
            tag_d.is_write = 1'b0;
            tag_d.err      = !hit0;
            if (hit0) begin
                mem_req   = 1'b1;
                mem_addr  = bus.h0_addr[13:2] - BASE_WORD;
                mem_wdata = bus.h1_wdata;
            end
        end else if (gnt1) begin
            last_d         = 1'b1;
            tag_d.valid    = 1'b1;
            tag_d.host     = 1'b1;
            tag_d.is_write = h1_write;
            tag_d.err      = !hit1;
            if (hit1) begin
                mem_req   = 1'b1;
                mem_addr  = bus.h1_addr[13:2] - BASE_WORD;
                mem_wdata = bus.h1_wdata;
                mem_we    = bus.h1_we;
            end
        end
    end

    // Response decode for the access tagged last cycle. A read hit relies on
    // the memory's rvalid; if it is missing the access is errored and the
    // sticky protocol-fault flag records it until the next reset.
    always_comb begin
        rsp_read_hit = tag_q.valid && !tag_q.err && !tag_q.is_write;
        rsp_err      = tag_q.err || (rsp_read_hit && !bus.mem_rvalid);
        rsp_data     = (rsp_read_hit && bus.mem_rvalid) ? bus.mem_rdata : 32'h0;
        fault_d      = fault_q || (rsp_read_hit && !bus.mem_rvalid);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            last_q  <= 1'b1;
            tag_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            tag_q   <= tag_d;
            fault_q <= fault_d;
        end
    end

    assign bus.h0_gnt    = gnt0;
    assign bus.h1_gnt    = gnt1;
    assign bus.mem_req   = mem_req;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_we    = mem_we;

    assign bus.h0_rvalid = tag_q.valid && !tag_q.host;
    assign bus.h1_rvalid = tag_q.valid &&  tag_q.host;
    assign bus.h0_err    = tag_q.valid && !tag_q.host && rsp_err;
    assign bus.h1_err    = tag_q.valid &&  tag_q.host && rsp_err;
    assign bus.h0_rdata  = !tag_q.host ? rsp_data : 32'h0;
    assign bus.h1_rdata  =  tag_q.host ? rsp_data : 32'h0;

endmodule
